waveform_capture: RTL and testbench

Circular sample buffer that sits between the ECG sample source and the waveform renderer. It writes decimated 8-bit samples into a DEPTH-entry dual-port BRAM. Each frame it snapshots a display base pointer, then replays one sample per screen column, indexed by hcount. It supplies the renderer's signal_in so that the oldest sample is drawn at column 0 and the newest at column DEPTH-1. A freeze control, applied only at frame boundaries, pauses capture for inspection.

---
 rtl/waveform_capture_if.sv | 24 ++
 rtl/waveform_capture.sv | 115 +++++++++++
 tb/tb_waveform_capture.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/waveform_capture_if.sv
// Sample-source / renderer bundle for the waveform capture buffer.
// The master side feeds samples and VGA timing; the slave side is the capture block.
interface waveform_capture_if;
    logic [7:0]  sample_in;
    logic        sample_valid;
    logic        freeze_req;
    logic        vsync;
    logic [10:0] hcount;
    logic [7:0]  signal_out;
    logic        col_valid;
    logic        full;
    logic        frozen;
    logic [1:0]  state;

    modport master (
        output sample_in, sample_valid, freeze_req, vsync, hcount,
        input  signal_out, col_valid, full, frozen, state
    );

    modport slave (
        input  sample_in, sample_valid, freeze_req, vsync, hcount,
        output signal_out, col_valid, full, frozen, state
    );
endinterface

// File: rtl/waveform_capture.sv
// Circular ECG sample buffer: decimated writes into a dual-port RAM, replayed one
// sample per screen column from a base pointer snapshotted at each frame start.
module waveform_capture #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DECIM  = 4
) (
    input logic          clock,
    input logic          reset_n,
    waveform_capture_if.slave bus
);

    localparam logic [1:0]        ST_FILL    = 2'd0;
    localparam logic [1:0]        ST_RUN     = 2'd1;
    localparam logic [1:0]        ST_FROZEN  = 2'd2;
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]        DECIM_LAST = 4'(DECIM - 1);
    localparam int                CMP_W      = (ADDR_W >= 11) ? ADDR_W + 1 : 12;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_ptr_next;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   fill_count;
    logic [3:0]        decim_cnt;
    logic [1:0]        cur_state;
    logic              vsync_prev;
    logic              full_q;
    logic              col_valid_q;
    logic              col_in_range;
    logic              accept;
    logic              store;
    logic              boundary;
    logic [7:0]        rd_data;
    logic [7:0]        mem [DEPTH];

    // Base is snapshotted from the post-write pointer so a same-cycle write still
    // leaves base on the oldest sample.
    always_comb begin
        accept       = bus.sample_valid && (cur_state != ST_FROZEN);
        store        = accept && (decim_cnt == DECIM_LAST);
        wr_ptr_next  = store ? wr_ptr + 1'b1 : wr_ptr;
        boundary     = bus.vsync && !vsync_prev;
        rd_addr      = base + bus.hcount[ADDR_W-1:0];
        col_in_range = (CMP_W'(bus.hcount) < CMP_W'(DEPTH)) &&
                       (CMP_W'(bus.hcount) < CMP_W'(fill_count));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            fill_count  <= '0;
            decim_cnt   <= '0;
            base        <= '0;
            cur_state   <= ST_FILL;
            vsync_prev  <= 1'b0;
            full_q      <= 1'b0;
            col_valid_q <= 1'b0;
        end else begin
            vsync_prev  <= bus.vsync;
            col_valid_q <= col_in_range;
            if (accept) begin
                decim_cnt <= store ? '0 : decim_cnt + 1'b1;
            end
            if (store) begin
                wr_ptr <= wr_ptr_next;
                if (fill_count != FULL_COUNT) begin
                    fill_count <= fill_count + 1'b1;
                end
            end
            if (fill_count == FULL_COUNT) begin
                full_q <= 1'b1;
            end
            // While filling, data starts at address 0, so base stays put until RUN.
            case (cur_state)
                ST_FILL: begin
                    if (boundary && bus.freeze_req) begin
                        cur_state <= ST_FROZEN;
                    end else if (fill_count == FULL_COUNT) begin
                        cur_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (boundary) begin
                        base <= wr_ptr_next;
                        if (bus.freeze_req) begin
                            cur_state <= ST_FROZEN;
                        end
                    end
                end
                ST_FROZEN: begin
                    if (boundary && !bus.freeze_req) begin
                        cur_state <= full_q ? ST_RUN : ST_FILL;
                    end
                end
                default: cur_state <= ST_FILL;
            endcase
        end
    end

    // Read-first RAM: a same-address write and read return the old contents.
    always_ff @(posedge clock) begin
        if (store) begin
            mem[wr_ptr] <= bus.sample_in;
        end
        rd_data <= mem[rd_addr];
    end

    assign bus.signal_out = col_valid_q ? rd_data : 8'd0;
    assign bus.col_valid  = col_valid_q;
    assign bus.full       = full_q;
    assign bus.frozen     = (cur_state == ST_FROZEN);
    assign bus.state      = cur_state;

endmodule

// File: tb/tb_waveform_capture.sv
// Bench for waveform_capture: directed vectors plus randomized traffic checked
// cycle by cycle against a sample-count based reference model.
module tb_waveform_capture;

    localparam int M_DEPTH  = 1024;
    localparam int M_DECIM  = 1;
    localparam int S_FILL   = 0;
    localparam int S_RUN    = 1;
    localparam int S_FROZEN = 2;

    typedef struct {
        int         hc;
        logic [7:0] exp_sig;
        logic       exp_valid;
    } sweep_vec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [7:0] m_mem [M_DEPTH];
    int         m_stored;
    int         m_accepted;
    int         m_state;
    int         m_base;
    bit         m_full;
    bit         m_pv;

    waveform_capture_if bus1 ();
    waveform_capture_if bus4 ();

    waveform_capture #(.DEPTH(1024), .ADDR_W(10), .DECIM(1)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    waveform_capture #(.DEPTH(16), .ADDR_W(4), .DECIM(4)) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock of the 1024-deep instance: the model predicts from the stored-sample
    // count, then every output is compared just after the edge.
    task automatic apply_stimulus(input logic sv, input logic [7:0] sin, input logic fr,
                                  input logic vs, input int hc);
        int         count;
        logic       e_valid;
        logic [7:0] e_sig;
        bit         edge_seen;
        bit         prev_full;
        bit         do_store;
        bus1.sample_valid = sv;
        bus1.sample_in    = sin;
        bus1.freeze_req   = fr;
        bus1.vsync        = vs;
        bus1.hcount       = 11'(hc);
        count     = (m_stored < M_DEPTH) ? m_stored : M_DEPTH;
        e_valid   = (hc < M_DEPTH) && (hc < count);
        e_sig     = e_valid ? m_mem[(m_base + hc) % M_DEPTH] : 8'd0;
        edge_seen = vs && !m_pv;
        m_pv      = vs;
        prev_full = m_full;
        m_full    = m_full || (count == M_DEPTH);
        do_store  = 1'b0;
        if (m_state != S_FROZEN && sv) begin
            do_store = ((m_accepted % M_DECIM) == M_DECIM - 1);
            m_accepted++;
        end
        if (do_store) begin
            m_mem[m_stored % M_DEPTH] = sin;
            m_stored++;
        end
        if (m_state == S_FILL) begin
            if (edge_seen && fr) m_state = S_FROZEN;
            else if (count == M_DEPTH) m_state = S_RUN;
        end else if (m_state == S_RUN) begin
            if (edge_seen) begin
                m_base = m_stored % M_DEPTH;
                if (fr) m_state = S_FROZEN;
            end
        end else if (edge_seen && !fr) begin
            m_state = prev_full ? S_RUN : S_FILL;
        end
        @(posedge clock);
        #1;
        check_output("signal_out", 32'(bus1.signal_out), 32'(e_sig));
        check_output("col_valid", 32'(bus1.col_valid), 32'(e_valid));
        check_output("state", 32'(bus1.state), 32'(m_state));
        check_output("full", 32'(bus1.full), 32'(m_full));
        check_output("frozen", 32'(bus1.frozen), 32'(m_state == S_FROZEN));
    endtask

    task automatic start_reset();
        bus1.sample_valid = 1'b0; bus1.sample_in = 8'd0; bus1.freeze_req = 1'b0;
        bus1.vsync = 1'b0; bus1.hcount = 11'd0;
        bus4.sample_valid = 1'b0; bus4.sample_in = 8'd0; bus4.freeze_req = 1'b0;
        bus4.vsync = 1'b0; bus4.hcount = 11'd0;
        reset_n    = 1'b0;
        m_stored   = 0;
        m_accepted = 0;
        m_state    = S_FILL;
        m_base     = 0;
        m_full     = 1'b0;
        m_pv       = 1'b0;
        #1;
        check_output("rst_signal_out", 32'(bus1.signal_out), 32'd0);
        check_output("rst_col_valid", 32'(bus1.col_valid), 32'd0);
        check_output("rst_full", 32'(bus1.full), 32'd0);
        check_output("rst_frozen", 32'(bus1.frozen), 32'd0);
        check_output("rst_state", 32'(bus1.state), 32'(S_FILL));
        check_output("rst4_col_valid", 32'(bus4.col_valid), 32'd0);
        check_output("rst4_state", 32'(bus4.state), 32'(S_FILL));
    endtask

    task automatic end_reset();
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sweep_vec_t vecs[6];
        logic       rvs;
        logic       rfr;
        int         n;

        vecs[0] = '{0, 8'h10, 1'b1};
        vecs[1] = '{1, 8'h11, 1'b1};
        vecs[2] = '{2, 8'h12, 1'b1};
        vecs[3] = '{3, 8'h00, 1'b0};
        vecs[4] = '{4, 8'h00, 1'b0};
        vecs[5] = '{5, 8'h00, 1'b0};

        $display("[TB] starting");
        #3;
        start_reset();
        end_reset();

        // Three stored samples read back in column order, then empty columns.
        apply_stimulus(1'b1, 8'h10, 1'b0, 1'b0, 0);
        apply_stimulus(1'b1, 8'h11, 1'b0, 1'b0, 0);
        apply_stimulus(1'b1, 8'h12, 1'b0, 1'b0, 0);
        foreach (vecs[i]) begin
            apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, vecs[i].hc);
            check_output("t1_sig", 32'(bus1.signal_out), 32'(vecs[i].exp_sig));
            check_output("t1_valid", 32'(bus1.col_valid), 32'(vecs[i].exp_valid));
        end

        // Decimate-by-4 instance keeps only every fourth strobe.
        for (int v = 1; v <= 8; v++) begin
            bus4.sample_valid = 1'b1;
            bus4.sample_in    = 8'(v);
            apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 0);
        end
        bus4.sample_valid = 1'b0;
        for (int h = 0; h < 3; h++) begin
            bus4.hcount = 11'(h);
            apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 0);
            check_output("t2_sig", 32'(bus4.signal_out), (h == 0) ? 32'd4 : (h == 1) ? 32'd8 : 32'd0);
            check_output("t2_valid", 32'(bus4.col_valid), (h < 2) ? 32'd1 : 32'd0);
        end
        check_output("t2_state", 32'(bus4.state), 32'(S_FILL));

        // Wrap past the end, then a frame edge snapshots base = 4.
        start_reset();
        end_reset();
        for (n = 0; n < 1028; n++) apply_stimulus(1'b1, 8'(n % 256), 1'b0, 1'b0, 0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 0);
        check_output("t3_state", 32'(bus1.state), 32'(S_RUN));
        check_output("t3_full", 32'(bus1.full), 32'd1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 0);
        check_output("t3_col0", 32'(bus1.signal_out), 32'h04);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1023);
        check_output("t3_col1023", 32'(bus1.signal_out), 32'h03);

        // Write coinciding with the frame edge at wr_ptr=100 gives base = 101.
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 0);
        for (n = 1028; n < 1124; n++) apply_stimulus(1'b1, 8'(n % 256), 1'b0, 1'b0, 0);
        apply_stimulus(1'b1, 8'hAB, 1'b0, 1'b1, 0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 0);
        check_output("t4_col0", 32'(bus1.signal_out), 32'h65);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1023);
        check_output("t4_col1023", 32'(bus1.signal_out), 32'hAB);

        // Freeze request waits for the frame edge; samples while frozen are dropped.
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 0);
        repeat (5) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 0);
        check_output("t5_not_yet", 32'(bus1.frozen), 32'd0);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1, 0);
        check_output("t5_frozen", 32'(bus1.frozen), 32'd1);
        check_output("t5_state", 32'(bus1.state), 32'(S_FROZEN));
        for (int h = 0; h < M_DEPTH; h++)
            apply_stimulus(h < 50, 8'($urandom), 1'b1, 1'b1, h);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 0);
        check_output("t5_resume", 32'(bus1.state), 32'(S_RUN));
        apply_stimulus(1'b1, 8'h5A, 1'b0, 1'b1, 0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 0);
        check_output("t5_held_ptr", 32'(bus1.signal_out), 32'h5A);

        // Asynchronous reset mid-sweep clears outputs without a clock edge.
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 0);
        for (int h = 0; h <= 300; h++) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, h);
        #2;
        start_reset();
        end_reset();

        rvs = 1'b0;
        rfr = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 59) == 0) rvs = !rvs;
            if ($urandom_range(0, 299) == 0) rfr = !rfr;
            apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom), rfr, rvs,
                           int'($urandom_range(0, 1279)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
